// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage:
// writeback select codes, load funct3 encodings and counter-control states.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LD   = 2'b01,
    WB_PC4  = 2'b10,
    WB_ZERO = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    CNT_IDLE = 1'b0,
    CNT_RUN  = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Load data aligner: picks the byte/half addressed by the load offset out of
// the word-aligned LSU word and sign- or zero-extends it to 32 bits.
module wb_load_align
  import wb_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  function automatic logic [31:0] sext8(input logic signed [7:0] b);
    return 32'(b);
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] h);
    return 32'(h);
  endfunction

  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  // Misaligned halfword loads do not trap; the low offset bit is dropped.
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_value = i_word;
    case (i_funct3)
      F3_LB:   o_value = sext8(w_byte);
      F3_LBU:  o_value = {24'h0, w_byte};
      F3_LH:   o_value = sext16(w_half);
      F3_LHU:  o_value = {16'h0, w_half};
      F3_LW:   o_value = i_word;
      default: o_value = i_word;
    endcase
  end

endmodule

// File: rtl/writeback_cycle.sv
// Writeback stage: register-file write port, one-cycle WB->ID bypass register,
// commit trace and the cycle / retire / control-transfer counters.
module writeback_cycle
  import wb_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int XLEN  = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [XLEN-1:0]  i_wb_pc_add4,
  input  logic [XLEN-1:0]  i_wb_alu_data,
  input  logic [XLEN-1:0]  i_wb_ld_data,
  input  logic [31:0]      i_wb_inst,
  input  logic [XLEN-1:0]  i_wb_pc_debug,
  input  logic [1:0]       i_wb_wb_sel,
  input  logic             i_wb_rd_wren,
  input  logic             i_wb_insn_vld,
  input  logic             i_wb_ctrl,
  input  logic             i_cnt_clr,
  output logic [4:0]       o_rf_wr_addr,
  output logic [XLEN-1:0]  o_rf_wr_data,
  output logic             o_rf_wr_en,
  output logic             o_byp_vld,
  output logic [4:0]       o_byp_addr,
  output logic [XLEN-1:0]  o_byp_data,
  output logic             o_cmt_vld,
  output logic [XLEN-1:0]  o_cmt_pc,
  output logic [31:0]      o_cmt_inst,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_retire_cnt,
  output logic [CNT_W-1:0] o_ctrl_cnt
);

  logic [31:0]      w_ld_aligned;
  logic [XLEN-1:0]  w_wr_data;
  logic [4:0]       w_rd;
  logic             w_wr_en;
  logic             w_cnt_en;
  cnt_state_e       r_state;
  cnt_state_e       w_state_nxt;

  logic             r_byp_vld_p1;
  logic [4:0]       r_byp_addr_p1;
  logic [XLEN-1:0]  r_byp_data_p1;
  logic             r_cmt_vld_p1;
  logic [XLEN-1:0]  r_cmt_pc_p1;
  logic [31:0]      r_cmt_inst_p1;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_ctrl_cnt;

  wb_load_align u_load_align (
    .i_word   (i_wb_ld_data[31:0]),
    .i_offset (i_wb_alu_data[1:0]),
    .i_funct3 (i_wb_inst[14:12]),
    .o_value  (w_ld_aligned)
  );

  // ---- stage p0: combinational register-file write port ----
  assign w_rd    = i_wb_inst[11:7];
  assign w_wr_en = i_wb_rd_wren & i_wb_insn_vld & (w_rd != 5'd0);

  always_comb begin
    w_wr_data = '0;
    case (wb_sel_e'(i_wb_wb_sel))
      WB_ALU:  w_wr_data = i_wb_alu_data;
      WB_LD:   w_wr_data = XLEN'(w_ld_aligned);
      WB_PC4:  w_wr_data = i_wb_pc_add4;
      default: w_wr_data = '0;
    endcase
  end

  assign o_rf_wr_addr = w_rd;
  assign o_rf_wr_data = w_wr_data;
  assign o_rf_wr_en   = w_wr_en;

  // ---- stage p1: bypass register and commit trace ----
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_byp_vld_p1  <= 1'b0;
      r_byp_addr_p1 <= '0;
      r_byp_data_p1 <= '0;
      r_cmt_vld_p1  <= 1'b0;
      r_cmt_pc_p1   <= '0;
      r_cmt_inst_p1 <= '0;
    end else begin
      r_byp_vld_p1  <= w_wr_en;
      r_byp_addr_p1 <= w_rd;
      r_byp_data_p1 <= w_wr_data;
      r_cmt_vld_p1  <= i_wb_insn_vld;
      if (i_wb_insn_vld) begin
        r_cmt_pc_p1   <= i_wb_pc_debug;
        r_cmt_inst_p1 <= i_wb_inst;
      end
    end
  end

  assign o_byp_vld  = r_byp_vld_p1;
  assign o_byp_addr = r_byp_addr_p1;
  assign o_byp_data = r_byp_data_p1;
  assign o_cmt_vld  = r_cmt_vld_p1;
  assign o_cmt_pc   = r_cmt_pc_p1;
  assign o_cmt_inst = r_cmt_inst_p1;

  // Counters stay frozen until the first real instruction reaches WB.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= CNT_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CNT_IDLE: if (i_wb_insn_vld && !i_cnt_clr) w_state_nxt = CNT_RUN;
      CNT_RUN:  if (i_cnt_clr) w_state_nxt = CNT_IDLE;
      default:  w_state_nxt = CNT_IDLE;
    endcase
  end

  // The retiring instruction that wakes the FSM is already counted.
  assign w_cnt_en = (r_state == CNT_RUN) | i_wb_insn_vld;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_ctrl_cnt   <= '0;
    end else if (i_cnt_clr) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_ctrl_cnt   <= '0;
    end else if (w_cnt_en) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (i_wb_insn_vld)
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      if (i_wb_insn_vld && i_wb_ctrl)
        r_ctrl_cnt <= r_ctrl_cnt + CNT_W'(1);
    end
  end

  assign o_cycle_cnt  = r_cycle_cnt;
  assign o_retire_cnt = r_retire_cnt;
  assign o_ctrl_cnt   = r_ctrl_cnt;

endmodule

// File: doc/writeback_cycle.md
Name: writeback_cycle

Overview:
- Final pipeline stage; consumes the memory stage's registered outputs.
- Aligns and extends load data, selects the register-file write value and drives the register-file write port. Suppresses writes to x0.
- Holds a one-cycle WB→ID bypass register, because the register file reads before it writes.
- Maintains the commit trace and the cycle, retired-instruction and control-transfer counters.

Parameters:
- CNT_W, 64, width of the cycle, retire and control-transfer counters.
- XLEN, 32, datapath width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_wb_pc_add4  in  XLEN  PC+4 of the instruction in WB.
- i_wb_alu_data  in  XLEN  ALU result; also the load address.
- i_wb_ld_data  in  XLEN  raw word-aligned load word from the LSU.
- i_wb_inst  in  32  instruction in WB.
- i_wb_pc_debug  in  XLEN  PC of the instruction in WB.
- i_wb_wb_sel  in  2  writeback select.
- i_wb_rd_wren  in  1  register write request.
- i_wb_insn_vld  in  1  instruction valid (not a bubble).
- i_wb_ctrl  in  1  instruction is a taken control transfer.
- i_cnt_clr  in  1  synchronous clear of all counters.
- o_rf_wr_addr  out  5  register-file write address, = inst[11:7].
- o_rf_wr_data  out  XLEN  register-file write data.
- o_rf_wr_en  out  1  register-file write enable.
- o_byp_vld  out  1  bypass entry valid.
- o_byp_addr  out  5  bypass register address.
- o_byp_data  out  XLEN  bypass data.
- o_cmt_vld  out  1  commit-trace valid.
- o_cmt_pc  out  XLEN  committed PC.
- o_cmt_inst  out  32  committed instruction.
- o_cycle_cnt  out  CNT_W  cycle counter.
- o_retire_cnt  out  CNT_W  retired-instruction counter.
- o_ctrl_cnt  out  CNT_W  retired control-transfer counter.

Behaviour:
- Write port (combinational, zero latency):
  - o_rf_wr_en = i_wb_rd_wren & i_wb_insn_vld & (inst[11:7] != 0).
  - o_rf_wr_data by wb_sel: 00 → alu_data; 01 → aligned load; 10 → pc_add4; 11 → 0.
- Load alignment: funct3 = inst[14:12]; offset = alu_data[1:0].
  - LB/LBU: byte at offset; sign- or zero-extend to 32 bits.
  - LH/LHU: half selected by offset[1]; offset[0] is ignored (no misaligned trap).
  - LW: full word.
  - Undefined funct3: full word.
- Bypass register (1-cycle latency): on every clock edge, o_byp_vld ← o_rf_wr_en, o_byp_addr ← o_rf_wr_addr, o_byp_data ← o_rf_wr_data. A bubble therefore clears o_byp_vld next cycle.
- Commit trace (1-cycle latency): o_cmt_vld ← i_wb_insn_vld. o_cmt_pc and o_cmt_inst load only when i_wb_insn_vld is 1 and otherwise hold their value.
- Counters:
  - cycle_cnt increments every cycle.
  - retire_cnt increments when insn_vld = 1.
  - ctrl_cnt increments when insn_vld & ctrl = 1.
  - All counters wrap from 2^CNT_W−1 to 0.
  - i_cnt_clr forces all counters to 0 on the next edge; it wins over a simultaneous increment (result 0, not 1).
- Counter-control FSM (2 states):
  - CNT_IDLE: entered on reset; counters hold. Moves to CNT_RUN on the first cycle with insn_vld = 1. That cycle's retirement is counted, and cycle_cnt starts from that edge.
  - CNT_RUN: counts as above. i_cnt_clr returns the FSM to CNT_IDLE.
- Reset (asynchronous, active-low, effective immediately mid-operation):
  - All registered outputs go to 0: o_byp_*, o_cmt_*, all counters. FSM goes to CNT_IDLE.
  - Combinational outputs follow their inputs. With no valid instruction, o_rf_wr_en = 0.

Decomposition:
- Shared package wb_pkg holds:
  - wb_sel_e: WB_ALU = 2'b00, WB_LD = 2'b01, WB_PC4 = 2'b10, WB_ZERO = 2'b11.
  - Load funct3 constants: F3_LB 000, F3_LH 001, F3_LW 010, F3_LBU 100, F3_LHU 101.
  - cnt_state_e: CNT_IDLE, CNT_RUN.
- One combinational sub-module, wb_load_align (inputs: word, offset, funct3; output: 32-bit value), unit-testable on its own.

Test Plan:
- LB, offset 3, word 0x80_12_34_56, wb_sel 01, rd = 5, valid → o_rf_wr_data 0xFFFFFF80, o_rf_wr_en 1. Same with LBU → 0x00000080. LHU, offset 2 → 0x00008012.
- JAL writing rd = 0 (wb_sel 10, rd_wren 1) → o_rf_wr_en 0; next cycle o_byp_vld 0. Same with rd = 1, pc_add4 0x104 → wr_data 0x104; next cycle o_byp_vld 1, addr 1, data 0x104.
- Reset release, then 3 bubbles, then 4 valid instructions (2 with ctrl) → cycle_cnt stays 0 through the bubbles; after the 4th instruction retire_cnt 4, ctrl_cnt 2, cycle_cnt 4.
- Preload retire_cnt to 2^64−1 via force, retire one instruction → 0. Assert i_cnt_clr together with a retirement → all counters 0, FSM CNT_IDLE.
- Assert reset low mid-stream with a valid write pending → o_byp_vld, o_cmt_vld and all counters 0 immediately, before the next clock edge.
- Bubble after a commit of PC 0x200 → o_cmt_vld 0, o_cmt_pc holds 0x200.
